key_debounce: RTL and testbench
===============================

// Module: key_debounce
// PURPOSE
//  Input-side conditioner for the board push-buttons: synchronises raw key pins, debounces each key
//  independently, and produces clean levels plus single-cycle press/release pulses.
//  Sits between the key pins and the responder's Key_In; Key_Press drives the answer-select logic
//  so a bouncing contact can never register as two presses or glitch the winner lockout.
// PARAMETERS
//  NUM_KEYS         4          number of independent keys
//  DEBOUNCE_CYCLES  1_000_000  clocks an input must hold a new value before it is accepted (20 ms @ 50 MHz); >= 2
//  KEY_ACTIVE_LOW   1          1: raw pin low = pressed; 0: raw pin high = pressed
// PORTS
//  CLK          in   1         system clock, all logic on rising edge
//  Rst          in   1         synchronous, active-high reset
//  Key_Raw      in   NUM_KEYS  asynchronous raw key pins
//  Key_Level    out  NUM_KEYS  debounced state, 1 = pressed (polarity-normalised)
//  Key_Press    out  NUM_KEYS  1-cycle pulse on accepted released->pressed transition
//  Key_Release  out  NUM_KEYS  1-cycle pulse on accepted pressed->released transition
// BEHAVIOUR
//  Reset (Rst high at a rising edge): sync flops load the "released" pin level; counters = 0;
//   Key_Level = 0, Key_Press = 0, Key_Release = 0. Reset wins over any in-flight count; no pulse is
//   emitted for the cycle reset is applied or for the first cycle after it.
//  Sync: 2-flop synchroniser per key; polarity normalised after stage 2 (s = pressed ? 1 : 0).
//  Per-key counter, width clog2(DEBOUNCE_CYCLES); no wrap possible, it is cleared before overflow:
//   - s == Key_Level            : counter <= 0 (any bounce back restarts the count).
//   - s != Key_Level, cnt <  DEBOUNCE_CYCLES-1 : counter <= counter+1.
//   - s != Key_Level, cnt == DEBOUNCE_CYCLES-1 : Key_Level <= s, counter <= 0,
//       Key_Press <= s, Key_Release <= ~s (registered, same edge as Key_Level update).
//  Pulses are high exactly one cycle, then 0; Press and Release never both high for one key.
//  Latency: raw pin stable from edge 0 -> Key_Level / pulse change at edge DEBOUNCE_CYCLES+2.
//  Glitch rejection: any excursion shorter than DEBOUNCE_CYCLES consecutive sampled clocks is ignored.
//  Keys are fully independent; simultaneous presses on several keys yield pulses in the same cycle
//   (arbitration between players is the consumer's job, not this block's).
//  Held key: Key_Level stays 1 indefinitely, no repeat pulses.
//  Key already pressed when reset releases: Level rises, and Key_Press fires, DEBOUNCE_CYCLES+2 cycles later.
// TESTING  (bench uses DEBOUNCE_CYCLES=4, NUM_KEYS=4, KEY_ACTIVE_LOW=1)
//  1. Rst=1 for 3 clocks with Key_Raw=4'b1111 -> Key_Level=0, Key_Press=0, Key_Release=0 throughout.
//  2. Key_Raw[0] 1->0 at edge 0, held -> Key_Level[0] rises at edge 6; Key_Press[0]=1 only at edge 6.
//  3. Key_Raw[1] low for 3 clocks, then high -> Key_Level[1], Key_Press[1] stay 0.
//  4. Bounce: Key_Raw[2] 0,1,0,0,0,0... -> count restarts; Level[2] rises 6 edges after final 1->0.
//  5. Key_Raw[1:0] released together after a held press -> Key_Release[1:0]=2'b11 for one cycle at +6.
//  6. Press Key_Raw[3], assert Rst at edge 3 for 1 cycle -> no pulse; Level[3] rises at edge 10.

Source files
------------

// File: rtl/key_debounce_if.sv
// Key pin / debounced key bundle between the pins and the responder.
// Carries raw pins in and clean levels plus edge pulses out.
interface key_debounce_if #(
  parameter int NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] Key_Raw;
  logic [NUM_KEYS-1:0] Key_Level;
  logic [NUM_KEYS-1:0] Key_Press;
  logic [NUM_KEYS-1:0] Key_Release;

  modport master (
    output Key_Raw,
    input  Key_Level,
    input  Key_Press,
    input  Key_Release
  );

  modport slave (
    input  Key_Raw,
    output Key_Level,
    output Key_Press,
    output Key_Release
  );
endinterface

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop sync, per-key debounce counter,
// clean pressed level and single-cycle press/release pulses.
module key_debounce #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic          CLK,
  input  logic          Rst,
  key_debounce_if.slave keys
);
  localparam int CW =
    (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_KEYS-1:0] IDLE_PIN =
    KEY_ACTIVE_LOW ? '1 : '0;

  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;
  logic [NUM_KEYS-1:0] s;
  logic [NUM_KEYS-1:0] level;
  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] rel;
  logic [CW-1:0]       cnt [NUM_KEYS];

  // Reset parks the synchroniser at the released pin level so that no
  // spurious disagreement is seen right after reset.
  always_ff @(posedge CLK) begin
    if (Rst) begin
      sync1 <= IDLE_PIN;
      sync2 <= IDLE_PIN;
    end else begin
      sync1 <= keys.Key_Raw;
      sync2 <= sync1;
    end
  end

  assign s = KEY_ACTIVE_LOW ? ~sync2 : sync2;

  always_ff @(posedge CLK) begin
    if (Rst) begin
      level <= '0;
      press <= '0;
      rel   <= '0;
      for (int k = 0; k < NUM_KEYS; k++)
        cnt[k] <= '0;
    end else begin
      press <= '0;
      rel   <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (s[k] == level[k]) begin
          cnt[k] <= '0;
        end else if (cnt[k] != CNT_MAX) begin
          cnt[k] <= cnt[k] + 1'b1;
        end else begin
          cnt[k]   <= '0;
          level[k] <= s[k];
          press[k] <= s[k];
          rel[k]   <= ~s[k];
        end
      end
    end
  end

  assign keys.Key_Level   = level;
  assign keys.Key_Press   = press;
  assign keys.Key_Release = rel;

endmodule

// File: tb/tb_key_debounce.sv
// Randomised and directed bench for key_debounce against a
// sliding-window model of the debounce rule.
module tb_key_debounce;
  localparam int N   = 4;
  localparam int D   = 4;
  localparam int LAT = D + 2;

  logic CLK = 1'b0;
  logic Rst = 1'b1;
  int   cmp = 0;
  int   mis = 0;
  int   cyc = 0;

  key_debounce_if #(.NUM_KEYS(N)) keys();

  key_debounce #(
    .NUM_KEYS(N),
    .DEBOUNCE_CYCLES(D),
    .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .CLK(CLK),
    .Rst(Rst),
    .keys(keys)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  // Model: a key flips when the synced sample has disagreed with the
  // accepted level for D consecutive non-reset edges.
  bit           rst_h[$];
  logic [N-1:0] pr_h[$];
  logic [N-1:0] s_h[$];
  logic [N-1:0] m_level = '0;
  logic [N-1:0] m_press = '0;
  logic [N-1:0] m_rel   = '0;

  task automatic tick();
    logic [N-1:0] r, sn, nl, np, nr;
    int idx;
    bit hit;
    r = Rst ? '0 : ~keys.Key_Raw;
    rst_h.push_back(Rst);
    pr_h.push_back(r);
    idx = rst_h.size() - 1;
    sn = '0;
    if (idx >= 2 && !rst_h[idx-1] && !rst_h[idx-2])
      sn = pr_h[idx-2];
    s_h.push_back(sn);
    nl = m_level;
    np = '0;
    nr = '0;
    if (Rst) begin
      nl = '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        hit = 1'b1;
        for (int j = 0; j < D; j++)
          if (idx - j < 0 || rst_h[idx-j] ||
              s_h[idx-j][k] == m_level[k])
            hit = 1'b0;
        if (hit) begin
          nl[k] = sn[k];
          np[k] = sn[k];
          nr[k] = ~sn[k];
        end
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
    m_level = nl;
    m_press = np;
    m_rel   = nr;
  endtask

  task automatic settle();
    keys.Key_Raw = '1;
    for (int i = 0; i < 10; i++) begin
      tick();
      cmp++;
      if ({keys.Key_Level, keys.Key_Press, keys.Key_Release}
          !== {m_level, m_press, m_rel}) begin
        $display("FAIL settle cyc=%0d got %b/%b/%b exp %b/%b/%b",
          cyc, keys.Key_Level, keys.Key_Press, keys.Key_Release,
          m_level, m_press, m_rel);
        mis++;
      end
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    keys.Key_Raw = '1;
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp++;
      if ({keys.Key_Level, keys.Key_Press, keys.Key_Release}
          !== 12'h000) begin
        $display("FAIL reset cyc=%0d got %b/%b/%b exp 0/0/0",
          cyc, keys.Key_Level, keys.Key_Press, keys.Key_Release);
        mis++;
      end
    end
    Rst = 1'b0;
    settle();
  endtask

  task automatic test_press();
    keys.Key_Raw[0] = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      cmp++;
      if (keys.Key_Level[0] !== (e >= LAT) ||
          keys.Key_Press[0] !== (e == LAT) ||
          keys.Key_Release[0] !== 1'b0) begin
        $display("FAIL press e=%0d got l%b p%b r%b",
          e, keys.Key_Level[0], keys.Key_Press[0],
          keys.Key_Release[0]);
        mis++;
      end
      cmp++;
      if (keys.Key_Level !== m_level) begin
        $display("FAIL press_model e=%0d got %b exp %b",
          e, keys.Key_Level, m_level);
        mis++;
      end
    end
    settle();
  endtask

  task automatic test_glitch();
    keys.Key_Raw[1] = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      if (e == 4) keys.Key_Raw[1] = 1'b1;
      tick();
      cmp++;
      if (keys.Key_Level[1] !== 1'b0 ||
          keys.Key_Press[1] !== 1'b0) begin
        $display("FAIL glitch e=%0d got l%b p%b exp l0 p0",
          e, keys.Key_Level[1], keys.Key_Press[1]);
        mis++;
      end
    end
    settle();
  endtask

  task automatic test_bounce();
    logic [3:0] pat;
    pat = 4'b0100;
    keys.Key_Raw[2] = pat[0];
    for (int e = 1; e <= 16; e++) begin
      if (e < 4) keys.Key_Raw[2] = pat[e];
      tick();
      cmp++;
      if (keys.Key_Level[2] !== (e >= 2 + LAT) ||
          keys.Key_Press[2] !== (e == 2 + LAT) ||
          keys.Key_Level !== m_level) begin
        $display("FAIL bounce e=%0d got l%b p%b exp l%b",
          e, keys.Key_Level[2], keys.Key_Press[2],
          m_level[2]);
        mis++;
      end
    end
    settle();
  endtask

  task automatic test_back_to_back();
    keys.Key_Raw[1:0] = 2'b00;
    for (int e = 1; e <= 10; e++) tick();
    cmp++;
    if (keys.Key_Level[1:0] !== 2'b11) begin
      $display("FAIL b2b_held got %b exp 11", keys.Key_Level[1:0]);
      mis++;
    end
    keys.Key_Raw[1:0] = 2'b11;
    for (int e = 1; e <= 10; e++) begin
      tick();
      cmp++;
      if (keys.Key_Release[1:0] !== ((e == LAT) ? 2'b11 : 2'b00) ||
          keys.Key_Press[1:0] !== 2'b00 ||
          keys.Key_Level[1:0] !== ((e >= LAT) ? 2'b00 : 2'b11)) begin
        $display("FAIL b2b e=%0d got r%b p%b l%b",
          e, keys.Key_Release[1:0], keys.Key_Press[1:0],
          keys.Key_Level[1:0]);
        mis++;
      end
    end
    settle();
  endtask

  task automatic test_reset_mid();
    keys.Key_Raw[3] = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      Rst = (e == 4);
      tick();
      cmp++;
      if (keys.Key_Level[3] !== (e >= 10) ||
          keys.Key_Press[3] !== (e == 10) ||
          keys.Key_Level !== m_level) begin
        $display("FAIL rst_mid e=%0d got l%b p%b exp l%b p%b",
          e, keys.Key_Level[3], keys.Key_Press[3],
          (e >= 10), (e == 10));
        mis++;
      end
    end
    Rst = 1'b0;
    settle();
  endtask

  task automatic test_random();
    int hold [N];
    for (int k = 0; k < N; k++) hold[k] = 0;
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < N; k++) begin
        if (hold[k] == 0) begin
          keys.Key_Raw[k] = 1'($urandom_range(0, 1));
          hold[k] = (($urandom & 3) == 0) ?
            $urandom_range(5, 14) : $urandom_range(1, 5);
        end
        hold[k]--;
      end
      Rst = ($urandom_range(0, 99) == 0);
      tick();
      cmp++;
      if ({keys.Key_Level, keys.Key_Press, keys.Key_Release}
          !== {m_level, m_press, m_rel}) begin
        $display("FAIL random cyc=%0d got %b/%b/%b exp %b/%b/%b",
          cyc, keys.Key_Level, keys.Key_Press, keys.Key_Release,
          m_level, m_press, m_rel);
        mis++;
      end
      cmp++;
      if ((keys.Key_Press & keys.Key_Release) !== '0) begin
        $display("FAIL both_pulses cyc=%0d got p%b r%b exp disjoint",
          cyc, keys.Key_Press, keys.Key_Release);
        mis++;
      end
    end
    Rst = 1'b0;
    settle();
  endtask

  initial begin
    keys.Key_Raw = '1;
    test_reset();
    test_press();
    test_glitch();
    test_bounce();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      cmp, mis);
    $finish;
  end

endmodule
